// File: rtl/parking_gate_controller.sv
// Single-lane parking barrier controller: arbitrates entry/exit requests,
// sequences the barrier through open/wait/close and tracks free spaces.
module parking_gate_controller #(
    parameter logic [7:0] TOTAL_SPACES = 8'd200,
    parameter int         OPEN_CYCLES  = 4,
    parameter int         PASS_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       car_passed,
    output logic       gate_open,
    output logic       entry_grant,
    output logic       exit_grant,
    output logic [7:0] free_spaces,
    output logic       full,
    output logic       empty,
    output logic       timeout_err
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] OPENING   = 2'd1;
    localparam logic [1:0] WAIT_PASS = 2'd2;
    localparam logic [1:0] CLOSING   = 2'd3;

    localparam logic [7:0] OPEN_LAST = 8'(OPEN_CYCLES - 1);
    localparam logic [7:0] PASS_LAST = 8'(PASS_TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0] free_q, free_d;
    logic       dir_entry_q, dir_entry_d;   // side being served by the current cycle
    logic       last_entry_q, last_entry_d; // 1 = entry won the last tie
    logic       gate_q, gate_d;
    logic       egrant_q, egrant_d;
    logic       xgrant_q, xgrant_d;
    logic       tout_q, tout_d;
    logic       ent_ok, ext_ok;

    assign full   = (free_q == 8'd0);
    assign empty  = (free_q == TOTAL_SPACES);
    assign ent_ok = entry_req && !full;
    assign ext_ok = exit_req && !empty;

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        free_d       = free_q;
        dir_entry_d  = dir_entry_q;
        last_entry_d = last_entry_q;
        egrant_d     = 1'b0;
        xgrant_d     = 1'b0;
        tout_d       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (ent_ok && ext_ok) begin
                    // tie: serve the side that did not win the previous tie
                    dir_entry_d  = !last_entry_q;
                    last_entry_d = !last_entry_q;
                    egrant_d     = !last_entry_q;
                    xgrant_d     = last_entry_q;
                    state_d      = OPENING;
                end else if (ent_ok) begin
                    dir_entry_d = 1'b1;
                    egrant_d    = 1'b1;
                    state_d     = OPENING;
                end else if (ext_ok) begin
                    dir_entry_d = 1'b0;
                    xgrant_d    = 1'b1;
                    state_d     = OPENING;
                end
            end
            OPENING: begin
                if (cnt_q >= OPEN_LAST) begin
                    state_d = WAIT_PASS;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_PASS: begin
                // a pass on the expiring cycle still counts as a pass
                if (car_passed) begin
                    free_d  = dir_entry_q ? free_q - 8'd1 : free_q + 8'd1;
                    state_d = CLOSING;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= PASS_LAST) begin
                    tout_d  = 1'b1;
                    state_d = CLOSING;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                if (cnt_q >= OPEN_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
        gate_d = (state_d == OPENING) || (state_d == WAIT_PASS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            free_q       <= TOTAL_SPACES;
            dir_entry_q  <= 1'b0;
            last_entry_q <= 1'b0;
            gate_q       <= 1'b0;
            egrant_q     <= 1'b0;
            xgrant_q     <= 1'b0;
            tout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            free_q       <= free_d;
            dir_entry_q  <= dir_entry_d;
            last_entry_q <= last_entry_d;
            gate_q       <= gate_d;
            egrant_q     <= egrant_d;
            xgrant_q     <= xgrant_d;
            tout_q       <= tout_d;
        end
    end

    assign gate_open   = gate_q;
    assign entry_grant = egrant_q;
    assign exit_grant  = xgrant_q;
    assign free_spaces = free_q;
    assign timeout_err = tout_q;

endmodule
